// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity helper for the UART echo block.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count; a push while full is taken only alongside a pop.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = level == FULL_LVL;
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART receiver feeding a FIFO that drains into a UART transmitter.
// Define UART_PARITY_EN to add a parity bit (sense set by PARITY_ODD) in both directions.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    input  logic                          tx_pause,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy
);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s1, rx_s, rx_q;
    uart_state_t          rx_state, tx_state;
    logic [CW-1:0]        rx_cnt, tx_cnt;
    logic [2:0]           rx_idx, tx_idx;
    logic [DATA_BITS-1:0] rx_shift, tx_shift, rdata;
    logic                 rx_brk, rx_tick, tx_tick;
    logic                 push, pop, full, empty;

    assign rx_tick = rx_cnt == BIT_END;
    assign tx_tick = tx_cnt == BIT_END;
    assign pop     = tx_state == IDLE && !empty && !tx_pause;

`ifdef UART_PARITY_EN
    localparam logic ODD = PARITY_ODD[0];
    logic rx_bad, tx_par;
    assign push = rx_state == STOP && !rx_brk && rx_tick && rx_s && !rx_bad;
`else
    assign push = rx_state == STOP && !rx_brk && rx_tick && rx_s;
    assign rx_parity_err = 1'b0;
`endif

    // uart_rx is asynchronous; rx_q is a third stage used only for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {rx_s1, rx_s, rx_q} <= 3'b111;
        else {rx_s1, rx_s, rx_q} <= {uart_rx, rx_s1, rx_s};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_brk       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overflow  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_bad        <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            rx_cnt <= rx_cnt + 1'b1;
            if (push && full && !pop) rx_overflow <= 1'b1;
            case (rx_state)
                IDLE: if (rx_q && !rx_s) begin
                    rx_cnt   <= '0;
                    rx_state <= START;
                end
                START: if (rx_cnt == HALF) begin
                    rx_cnt   <= '0;
                    rx_idx   <= '0;
                    rx_state <= rx_s ? IDLE : DATA;
                end
                DATA: if (rx_tick) begin
                    rx_cnt   <= '0;
                    rx_idx   <= rx_idx + 1'b1;
                    rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
                    if (rx_idx == LAST_BIT) rx_state <= PARITY;
`else
                    if (rx_idx == LAST_BIT) rx_state <= STOP;
`endif
                end
`ifdef UART_PARITY_EN
                PARITY: if (rx_tick) begin
                    rx_cnt        <= '0;
                    rx_bad        <= rx_s != parity_bit(8'(rx_shift), ODD);
                    rx_parity_err <= rx_s != parity_bit(8'(rx_shift), ODD);
                    rx_state      <= STOP;
                end
`endif
                // a low stop bit means a break: hold here until the line idles high
                STOP: if (rx_brk) begin
                    if (rx_s) begin
                        rx_brk   <= 1'b0;
                        rx_state <= IDLE;
                    end
                end else if (rx_tick) begin
                    if (rx_s) rx_state <= IDLE;
                    else begin
                        rx_frame_err <= 1'b1;
                        rx_brk       <= 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                IDLE: if (pop) begin
                    tx_shift <= rdata;
`ifdef UART_PARITY_EN
                    tx_par   <= parity_bit(8'(rdata), ODD);
`endif
                    tx_cnt   <= '0;
                    uart_tx  <= 1'b0;
                    tx_busy  <= 1'b1;
                    tx_state <= START;
                end
                START: if (tx_tick) begin
                    tx_cnt   <= '0;
                    tx_idx   <= '0;
                    uart_tx  <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_state <= DATA;
                end
                DATA: if (tx_tick) begin
                    tx_cnt <= '0;
                    tx_idx <= tx_idx + 1'b1;
                    if (tx_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        uart_tx  <= tx_par;
                        tx_state <= PARITY;
`else
                        uart_tx  <= 1'b1;
                        tx_state <= STOP;
`endif
                    end else begin
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: if (tx_tick) begin
                    tx_cnt   <= '0;
                    uart_tx  <= 1'b1;
                    tx_state <= STOP;
                end
`endif
                STOP: if (tx_cnt == STOP_END) begin
                    tx_busy  <= 1'b0;
                    tx_state <= IDLE;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (rx_shift),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed echo scenarios with an expected-byte scoreboard checked against frames decoded from uart_tx.
module tb_uart_echo_fifo;
    localparam int CPB    = 16;
    localparam int DB     = 8;
    localparam int DEPTH  = 16;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, tx_pause = 1'b0;
    logic       uart_tx, rx_frame_err, rx_parity_err, rx_overflow, tx_busy;
    logic [4:0] fifo_level;

    int total = 0, bad = 0;
    int ferr_n = 0, perr_n = 0, peak = 0, rst_cnt = 0, gi = 0, mon_r0 = 0;
    logic peak_clr = 1'b0;
    logic [7:0]  exp_q [$];
    logic [11:0] got [$];
    logic [11:0] mon_f;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_echo_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB),
        .STOP_BITS(1),
        .FIFO_DEPTH(DEPTH),
        .PARITY_ODD(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .uart_tx      (uart_tx),
        .tx_pause     (tx_pause),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overflow  (rx_overflow),
        .fifo_level   (fifo_level),
        .tx_busy      (tx_busy)
    );

    always #42 clk = ~clk;

    always @(posedge rst) rst_cnt++;

    always @(negedge clk) begin
        if (rx_frame_err) ferr_n++;
        if (rx_parity_err) perr_n++;
        if (peak_clr) peak = 0;
        else if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end

    // decode frames on uart_tx at bit centres: {parity, stop, start, data}; frames cut by reset are dropped
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                mon_r0 = rst_cnt;
                mon_f  = '0;
                repeat (CPB / 2) @(negedge clk);
                mon_f[8] = uart_tx;
                for (int i = 0; i < DB; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_f[i] = uart_tx;
                end
`ifdef UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                mon_f[10] = uart_tx;
`endif
                repeat (CPB) @(negedge clk);
                mon_f[9] = uart_tx;
                if (rst_cnt == mon_r0) got.push_back(mon_f);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        uart_rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        logic [11:0] f;
        logic [7:0]  e;
        while ((got.size() - gi < exp_q.size() || tx_busy || fifo_level != 0) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (2 * CPB) @(negedge clk);
        check("drain_timeout", n < BUDGET, 1);
        check("frame_count", got.size() - gi, exp_q.size());
        while (gi < got.size() && exp_q.size() > 0) begin
            f = got[gi];
            gi++;
            e = exp_q.pop_front();
            check("tx_data", f[7:0], e);
            check("tx_start", f[8], 0);
            check("tx_stop", f[9], 1);
`ifdef UART_PARITY_EN
            check("tx_parity", f[10], ^e);
`endif
        end
        gi = got.size();
        exp_q.delete();
    endtask

    initial begin
        int g0, e0, n;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_frame_err", rx_frame_err, 0);
        check("rst_parity_err", rx_parity_err, 0);
        check("rst_overflow", rx_overflow, 0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        e0 = ferr_n;
        exp_q.push_back(8'h0D);
        send(8'h0D, 1'b1);
        exp_q.push_back(8'h0A);
        send(8'h0A, 1'b1);
        drain();
        check("crlf_peak", peak, 1);
        check("crlf_frame_err", ferr_n - e0, 0);
        check("crlf_overflow", rx_overflow, 0);

        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        g0 = got.size();
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_peak", peak, 0);
        check("glitch_frame_err", ferr_n - e0, 0);
        check("glitch_no_echo", got.size(), g0);
        check("glitch_tx_idle", uart_tx, 1);

        send(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("break_frame_err", ferr_n - e0, 1);
        check("break_no_echo", got.size(), g0);
        check("break_level", fifo_level, 0);
        exp_q.push_back(8'h41);
        send(8'h41, 1'b1);
        drain();

        tx_pause = 1'b1;
        g0 = got.size();
        for (int b = 0; b <= DEPTH; b++) begin
            if (b < DEPTH) exp_q.push_back(8'(b));
            send(8'(b), 1'b1);
        end
        repeat (2 * CPB) @(negedge clk);
        check("pause_level", fifo_level, DEPTH);
        check("pause_overflow", rx_overflow, 1);
        check("pause_no_echo", got.size(), g0);
        tx_pause = 1'b0;
        drain();
        check("overflow_sticky", rx_overflow, 1);

        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        n = 0;
        while (!tx_busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("a5_tx_started", n < BUDGET, 1);
        repeat (3 * CPB + 3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_uart_tx", uart_tx, 1);
        check("midrst_level", fifo_level, 0);
        check("midrst_overflow", rx_overflow, 0);
        check("midrst_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (12 * CPB) @(negedge clk);
        gi = got.size();
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        drain();

`ifdef UART_PARITY_EN
        e0 = perr_n;
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1);
        drain();
        g0 = got.size();
        par_flip = 1'b1;
        send(8'h07, 1'b1);
        par_flip = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("parity_err_pulse", perr_n - e0, 1);
        check("parity_no_echo", got.size(), g0);
        check("parity_level", fifo_level, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
